// File: rtl/amp_seq_pkg.sv
// Shared types and default register table for the class-D amp power sequencer.
package amp_seq_pkg;

   typedef enum logic [2:0] {
      ST_OFF       = 3'd0,
      ST_PWRUP     = 3'd1,
      ST_CFG_REQ   = 3'd2,
      ST_CFG_WAIT  = 3'd3,
      ST_UNMUTE    = 3'd4,
      ST_RUN       = 3'd5,
      ST_MUTE_HOLD = 3'd6,
      ST_FAULT     = 3'd7
   } state_t;

   // One table entry: register address in [15:8], data in [7:0].
   localparam int CFG_ENTRY = 16;
   typedef logic [CFG_ENTRY-1:0] cfg_entry_t;

   localparam cfg_entry_t CFG_RESET_REL = 16'h01_00;
   localparam cfg_entry_t CFG_CLK_I2S   = 16'h02_10;
   localparam cfg_entry_t CFG_BCK_32FS  = 16'h03_05;
   localparam cfg_entry_t CFG_VOL_0DB   = 16'h4C_30;
   localparam cfg_entry_t CFG_DSP_BYP   = 16'h08_01;
   localparam cfg_entry_t CFG_EXIT_STBY = 16'h04_00;

endpackage

// File: rtl/amp_cfg_rom.sv
// Combinational config table lookup; indices past NUM_CFG read as zero.
module amp_cfg_rom
   import amp_seq_pkg::*;
#(
   parameter int NUM_CFG = 6
) (
   input  logic [3:0]           index,
   output logic [CFG_ENTRY-1:0] entry
);

   always_comb begin
      entry = '0;
      if (int'(index) < NUM_CFG) begin
         case (index)
            4'd0:    entry = CFG_RESET_REL;
            4'd1:    entry = CFG_CLK_I2S;
            4'd2:    entry = CFG_BCK_32FS;
            4'd3:    entry = CFG_VOL_0DB;
            4'd4:    entry = CFG_DSP_BYP;
            4'd5:    entry = CFG_EXIT_STBY;
            default: entry = '0;
         endcase
      end
   end

endmodule

// File: rtl/amp_power_seq.sv
// Amp power sequencer: enable, I2C config with retry, lock-gated unmute,
// and muted hold before shutdown.
module amp_power_seq
   import amp_seq_pkg::*;
#(
   parameter int T_EN_CYC     = 4800,
   parameter int T_UNMUTE_CYC = 2400,
   parameter int T_OFF_CYC    = 48000,
   parameter int NUM_CFG      = 6,
   parameter int RETRY_MAX    = 3,
   parameter int CNT_W        = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       audio_locked,
   output logic       i2c_req,
   output logic [7:0] i2c_reg,
   output logic [7:0] i2c_wdata,
   input  logic       i2c_done,
   input  logic       i2c_nack,
   output logic       amp_nenable,
   output logic       amp_mute,
   output logic       fault,
   output logic [2:0] state_o
);

   localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(T_EN_CYC - 1);
   localparam logic [CNT_W-1:0] UN_LAST  = CNT_W'(T_UNMUTE_CYC - 1);
   localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(T_OFF_CYC - 1);
   localparam logic [3:0]       IDX_LAST = 4'(NUM_CFG - 1);
   localparam logic [3:0]       RTY_LAST = 4'(RETRY_MAX - 1);

   state_t               state;
   logic [CNT_W-1:0]     timer;
   logic [3:0]           index;
   logic [3:0]           retry;
   logic [CFG_ENTRY-1:0] entry;

   amp_cfg_rom #(.NUM_CFG(NUM_CFG)) u_rom (
      .index (index),
      .entry (entry)
   );

   assign state_o = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_OFF;
         timer       <= '0;
         index       <= '0;
         retry       <= '0;
         i2c_req     <= 1'b0;
         i2c_reg     <= '0;
         i2c_wdata   <= '0;
         amp_nenable <= 1'b1;
         amp_mute    <= 1'b1;
         fault       <= 1'b0;
      end else begin
         i2c_req <= 1'b0;
         // Losing enable beats every sequencing event, including a pending done.
         if (!enable && state != ST_OFF && state != ST_FAULT) begin
            state       <= ST_OFF;
            timer       <= '0;
            amp_mute    <= 1'b1;
            amp_nenable <= 1'b1;
         end else begin
            case (state)
               ST_OFF: begin
                  if (enable && audio_locked) begin
                     state       <= ST_PWRUP;
                     timer       <= '0;
                     amp_nenable <= 1'b0;
                  end
               end
               ST_PWRUP: begin
                  if (timer == EN_LAST) begin
                     state <= ST_CFG_REQ;
                     timer <= '0;
                     index <= '0;
                     retry <= '0;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
               ST_CFG_REQ: begin
                  i2c_req   <= 1'b1;
                  i2c_reg   <= entry[15:8];
                  i2c_wdata <= entry[7:0];
                  state     <= ST_CFG_WAIT;
               end
               ST_CFG_WAIT: begin
                  if (i2c_done) begin
                     if (!i2c_nack) begin
                        if (index == IDX_LAST) begin
                           state <= ST_UNMUTE;
                           timer <= '0;
                        end else begin
                           index <= index + 4'd1;
                           retry <= '0;
                           state <= ST_CFG_REQ;
                        end
                     end else if (retry == RTY_LAST) begin
                        state       <= ST_FAULT;
                        fault       <= 1'b1;
                        amp_nenable <= 1'b1;
                        amp_mute    <= 1'b1;
                     end else begin
                        retry <= retry + 4'd1;
                        state <= ST_CFG_REQ;
                     end
                  end
               end
               ST_UNMUTE: begin
                  // Unmute needs an unbroken run of locked cycles.
                  if (!audio_locked) begin
                     timer <= '0;
                  end else if (timer == UN_LAST) begin
                     state    <= ST_RUN;
                     amp_mute <= 1'b0;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
               ST_RUN: begin
                  if (!audio_locked) begin
                     state    <= ST_MUTE_HOLD;
                     amp_mute <= 1'b1;
                     timer    <= '0;
                  end
               end
               ST_MUTE_HOLD: begin
                  if (audio_locked) begin
                     state <= ST_UNMUTE;
                     timer <= '0;
                  end else if (timer == OFF_LAST) begin
                     state       <= ST_OFF;
                     timer       <= '0;
                     amp_nenable <= 1'b1;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
               ST_FAULT: begin
                  if (!enable) state <= ST_OFF;
               end
               default: state <= ST_OFF;
            endcase
         end
      end
   end

endmodule
